sprite_palette_lut: RTL and testbench
=====================================

# sprite_palette_lut

Parametrised, runtime-writable sprite palette for the VGA pixel path. Converts a per-pixel colour index from a sprite ROM into RGB with a fixed two-cycle pipeline. It supports several palette banks, selected per frame, for per-player recolouring and animation, and flags transparent pixels for the compositor. It sits between the sprite ROM address/index stage and the layer mux that feeds the VGA output.

## Interface
Parameters:
- IDX_W, 4: colour-index width; palette has 2**IDX_W entries per bank.
- CH_W, 4: bits per colour channel.
- BANKS, 2: number of palette banks (≥1). BW = max(1, $clog2(BANKS)).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- pix_valid_i  in  1  lookup request this cycle.
- pix_idx_i  in  IDX_W  colour index.
- frame_start_i  in  1  one-cycle pulse at start of vertical blank.
- bank_req_i  in  BW  bank to use for the next frame.
- wr_en_i  in  1  palette write strobe.
- wr_bank_i  in  BW  write bank.
- wr_idx_i  in  IDX_W  write entry.
- wr_rgb_i  in  3*CH_W  {R,G,B} to store.
- flash_i  in  1  hit-flash request (see Configuration).
- init_busy_o  out  1  default-palette load in progress.
- pix_valid_o  out  1  output pixel valid.
- red_o, green_o, blue_o  out  CH_W each  looked-up colour.
- transparent_o  out  1  stored colour equals KEY colour.

## Operation
- Storage: BANKS × 2**IDX_W words of 3*CH_W bits. Synchronous read, one write port, read-first.
- FSM states:
  - INIT: entered on reset. Writes DEFAULT_PAL[i] to entry i of every bank, one address per cycle. A counter runs over BANKS*2**IDX_W words. init_busy_o=1. wr_en_i and pix_valid_i are ignored, and pix_valid_o=0.
  - RUN: entered the cycle after the last init write. Normal lookups and writes.
  - Reset_n low in any state returns to INIT with the counter at 0. The pipeline is flushed.
- Active bank register: loaded from bank_req_i when frame_start_i=1 in RUN; reset value 0. Requests with bank_req_i ≥ BANKS are ignored, and the bank is unchanged.
- Each lookup is tagged with the active bank at issue. A bank change never affects in-flight pixels.
- Writes: in RUN with wr_en_i=1, the entry is updated at the clock edge. Writes with wr_bank_i ≥ BANKS are dropped.
- Same-entry read and write in one cycle: the lookup returns the old value. Lookups issued from the next cycle on see the new value.
- Transparency: transparent_o=1 when the stored word equals KEY = {all-ones, zero, all-ones}, i.e. F0F at CH_W=4. RGB is still driven with the stored value.
- When pix_valid_o=0, RGB holds its previous value and transparent_o=0.

## Timing
- Latency: request at cycle N produces pix_valid_o and data at cycle N+2. Throughput is one pixel per cycle, with no stalls and no backpressure.
- Reset values: init_busy_o=1, pix_valid_o=0, RGB=0, transparent_o=0, active bank=0.
- Init duration: BANKS*2**IDX_W cycles after Reset_n rises (32 with defaults). init_busy_o falls at the edge entering RUN.
- frame_start_i and a write in the same cycle are independent. Both take effect.

## Configuration
- SPRITE_PAL_FLASH_EN defined:
  - flash_i is sampled with the request and pipelined alongside it.
  - For a non-transparent pixel with flash set, RGB output is forced to all-ones.
  - Transparent pixels are unaffected.
- Not defined: flash_i is ignored, and the output is always the stored colour. The port remains present.

## Structure
- Package sprite_pal_pkg contains:
  - DEFAULT_PAL constant (16 × 12-bit for defaults; entry 0 = KEY).
  - KEY constant function of CH_W.
  - The state enum {INIT, RUN}.
- One sub-module, sprite_pal_ram: banked synchronous read-first RAM with a single write port.

## Test plan
- Reset release → init_busy_o high for exactly 32 cycles. Idx 0 and idx 1 of bank 0 then return DEFAULT_PAL values 2 cycles after request. Idx 0 gives transparent_o=1.
- Write bank1 idx3=0x123, pulse frame_start_i with bank_req_i=1, then look up idx3 → RGB 1/2/3 at N+2, transparent_o=0.
- Back-to-back lookups idx 0..15 → 16 consecutive valid outputs in order. A bank switch mid-stream leaves already-issued pixels on the old bank.
- Same-cycle write idx5=0xABC and lookup idx5 → old value. A lookup on the next cycle gives 0xABC.
- Reset_n low mid-init (cycle 10) → init restarts and busy lasts another full 32 cycles. Reset_n low during RUN flushes pix_valid_o to 0 and restores default colours.
- With SPRITE_PAL_FLASH_EN: flash_i=1 on idx1 → RGB F/F/F; on idx0 → transparent_o=1 and RGB F/0/F. Without the macro: idx1 → its stored colour.

Source files
------------

// File: rtl/sprite_pal_pkg.sv
// Shared types and constants for the sprite palette: default palette, colour key and FSM states.
package sprite_pal_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entry 0 is the transparent key; the rest form a grey ramp so every entry is distinct.
    localparam logic [11:0] DEFAULT_PAL [16] = '{
        12'hF0F, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777,
        12'h888, 12'h999, 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'hEEE, 12'hFFF
    };

    function automatic logic [47:0] key_color(input int ch_w);
        logic [47:0] k;
        k = 48'h0;
        for (int i = 0; i < ch_w; i++) begin
            k[i]            = 1'b1;
            k[2 * ch_w + i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/sprite_pal_ram.sv
// Banked palette storage: synchronous read-first RAM with a single write port.
module sprite_pal_ram #(
    parameter int AW    = 5,
    parameter int DW    = 12,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read returns the pre-write contents when both ports hit the same word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// Two-stage sprite palette lookup with per-frame bank select and transparency flag.
// Optional hit-flash override enabled by defining SPRITE_PAL_FLASH_EN.
module sprite_palette_lut
    import sprite_pal_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int BANKS = 2,
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_valid_i,
    input  logic [IDX_W-1:0]  pix_idx_i,
    input  logic              frame_start_i,
    input  logic [BW-1:0]     bank_req_i,
    input  logic              wr_en_i,
    input  logic [BW-1:0]     wr_bank_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [3*CH_W-1:0] wr_rgb_i,
    input  logic              flash_i,
    output logic              init_busy_o,
    output logic              pix_valid_o,
    output logic [CH_W-1:0]   red_o,
    output logic [CH_W-1:0]   green_o,
    output logic [CH_W-1:0]   blue_o,
    output logic              transparent_o
);

    localparam int WORDS = BANKS * (2 ** IDX_W);
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int DW    = 3 * CH_W;
    localparam logic [DW-1:0] KEY  = DW'(key_color(CH_W));
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     init_cnt_q, init_cnt_d;
    logic              init_busy_q, init_busy_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic              vld1_q, vld1_d;
    logic              flash1_q, flash1_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DW-1:0]     rgb_q, rgb_d;
    logic              trans_q, trans_d;

    logic              ram_we_s;
    logic [AW-1:0]     ram_waddr_s;
    logic [DW-1:0]     ram_wdata_s;
    logic [AW-1:0]     ram_raddr_s;
    logic [DW-1:0]     rd_data_s;
    logic [IDX_W-1:0]  init_idx_s;
    logic [DW-1:0]     def_word_s;
    logic              flash_s;

`ifdef SPRITE_PAL_FLASH_EN
    assign flash_s = flash_i;
`else
    logic unused_flash_s;
    assign unused_flash_s = flash_i;
    assign flash_s        = 1'b0;
`endif

    // Words are laid out bank-major, so the low IDX_W counter bits are the entry index.
    always_comb begin
        init_idx_s = IDX_W'(init_cnt_q);
        if (init_idx_s == '0) begin
            def_word_s = KEY;
        end else if (CH_W == 4 && IDX_W <= 4) begin
            def_word_s = DW'(DEFAULT_PAL[4'(init_idx_s)]);
        end else begin
            def_word_s = {3{CH_W'(init_idx_s)}};
        end
    end

    // Next-state, write-port arbitration and output pipeline.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_busy_d = init_busy_q;
        bank_d      = bank_q;
        vld1_d      = 1'b0;
        flash1_d    = 1'b0;
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        case (state_q)
            INIT: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = init_cnt_q;
                ram_wdata_s = def_word_s;
                if (init_cnt_q == LAST) begin
                    state_d     = RUN;
                    init_cnt_d  = '0;
                    init_busy_d = 1'b0;
                end else begin
                    init_cnt_d  = init_cnt_q + AW'(1);
                    init_busy_d = 1'b1;
                end
            end
            RUN: begin
                init_busy_d = 1'b0;
                if (wr_en_i && (int'(wr_bank_i) < BANKS)) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = AW'({wr_bank_i, wr_idx_i});
                    ram_wdata_s = wr_rgb_i;
                end else begin
                    ram_we_s    = 1'b0;
                end
                if (frame_start_i && (int'(bank_req_i) < BANKS)) begin
                    bank_d = bank_req_i;
                end else begin
                    bank_d = bank_q;
                end
                vld1_d   = pix_valid_i;
                flash1_d = pix_valid_i & flash_s;
            end
            default: begin
                state_d     = INIT;
                init_cnt_d  = '0;
                init_busy_d = 1'b1;
            end
        endcase

        // The bank is folded into the read address at issue, so later bank changes cannot touch it.
        ram_raddr_s = AW'({bank_q, pix_idx_i});

        pix_valid_d = vld1_q;
        if (vld1_q) begin
            trans_d = (rd_data_s == KEY);
            if (flash1_q && !trans_d) begin
                rgb_d = '1;
            end else begin
                rgb_d = rd_data_s;
            end
        end else begin
            trans_d = 1'b0;
            rgb_d   = rgb_q;
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
            bank_q      <= '0;
            vld1_q      <= 1'b0;
            flash1_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            rgb_q       <= '0;
            trans_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_busy_q <= init_busy_d;
            bank_q      <= bank_d;
            vld1_q      <= vld1_d;
            flash1_q    <= flash1_d;
            pix_valid_q <= pix_valid_d;
            rgb_q       <= rgb_d;
            trans_q     <= trans_d;
        end
    end

    sprite_pal_ram #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (WORDS)
    ) u_ram (
        .clk     (Clk),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i (ram_wdata_s),
        .raddr_i (ram_raddr_s),
        .rdata_o (rd_data_s)
    );

    assign init_busy_o   = init_busy_q;
    assign pix_valid_o   = pix_valid_q;
    assign red_o         = rgb_q[DW-1 -: CH_W];
    assign green_o       = rgb_q[2*CH_W-1 -: CH_W];
    assign blue_o        = rgb_q[CH_W-1:0];
    assign transparent_o = trans_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed scoreboard bench for sprite_palette_lut at default parameters.
module tb_sprite_palette_lut;

    logic        Clk;
    logic        Reset_n;
    logic        pix_valid_i;
    logic [3:0]  pix_idx_i;
    logic        frame_start_i;
    logic [0:0]  bank_req_i;
    logic        wr_en_i;
    logic [0:0]  wr_bank_i;
    logic [3:0]  wr_idx_i;
    logic [11:0] wr_rgb_i;
    logic        flash_i;
    logic        init_busy_o;
    logic        pix_valid_o;
    logic [3:0]  red_o, green_o, blue_o;
    logic        transparent_o;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        trans;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] model [2][16];
    logic [0:0]  bank_m;
    int          cyc;
    int          total_cnt;
    int          pass_cnt;
    int          fail_cnt;

    sprite_palette_lut dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .pix_valid_i   (pix_valid_i),
        .pix_idx_i     (pix_idx_i),
        .frame_start_i (frame_start_i),
        .bank_req_i    (bank_req_i),
        .wr_en_i       (wr_en_i),
        .wr_bank_i     (wr_bank_i),
        .wr_idx_i      (wr_idx_i),
        .wr_rgb_i      (wr_rgb_i),
        .flash_i       (flash_i),
        .init_busy_o   (init_busy_o),
        .pix_valid_o   (pix_valid_o),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .transparent_o (transparent_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            model[b][0] = 12'hF0F;
            for (int i = 1; i < 16; i++) model[b][i] = 12'(i * 12'h111);
        end
        bank_m = 1'b0;
    endtask

    task automatic clear_inputs();
        pix_valid_i = 1'b0; pix_idx_i = 4'd0; flash_i = 1'b0;
        wr_en_i = 1'b0; wr_bank_i = 1'b0; wr_idx_i = 4'd0; wr_rgb_i = 12'h000;
        frame_start_i = 1'b0; bank_req_i = 1'b0;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge Clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("pix_valid", {31'd0, pix_valid_o}, 32'd1);
            chk("rgb", {20'd0, red_o, green_o, blue_o}, {20'd0, e.rgb});
            chk("transparent", {31'd0, transparent_o}, {31'd0, e.trans});
        end else begin
            chk("idle_valid", {31'd0, pix_valid_o}, 32'd0);
            chk("idle_transparent", {31'd0, transparent_o}, 32'd0);
        end
        @(negedge Clk);
    endtask

    task automatic cycle(input logic v, input logic [3:0] idx, input logic fl,
                         input logic we, input logic wb, input logic [3:0] wi,
                         input logic [11:0] wd, input logic fs, input logic br);
        exp_t e;
        pix_valid_i = v; pix_idx_i = idx; flash_i = fl;
        wr_en_i = we; wr_bank_i = wb; wr_idx_i = wi; wr_rgb_i = wd;
        frame_start_i = fs; bank_req_i = br;
        if (v) begin
            e.due   = cyc + 2;
            e.rgb   = model[bank_m][idx];
            e.trans = (e.rgb == 12'hF0F);
`ifdef SPRITE_PAL_FLASH_EN
            if (fl && !e.trans) e.rgb = 12'hFFF;
`endif
            sb.push_back(e);
        end
        if (we) model[wb][wi] = wd;
        if (fs) bank_m = br;
        tick();
        clear_inputs();
    endtask

    task automatic look(input logic [3:0] idx, input logic fl);
        cycle(1'b1, idx, fl, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
    endtask

    // Busy must drop on exactly the 32nd edge after release; bounded so a stuck FSM still ends.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            n = k;
            if (init_busy_o == 1'b0) break;
        end
        chk(tag, n, 32'd32);
    endtask

    initial begin
        cyc = 0; total_cnt = 0; pass_cnt = 0; fail_cnt = 0;
        clear_inputs();
        model_reset();
        Reset_n = 1'b0;
        @(negedge Clk);
        tick();
        tick();
        chk("reset_busy", {31'd0, init_busy_o}, 32'd1);
        chk("reset_rgb", {20'd0, red_o, green_o, blue_o}, 32'd0);

        // Release, then pull reset at cycle 10 of init: the full init must restart.
        Reset_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("mid_init_busy", {31'd0, init_busy_o}, 32'd1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        // Lookups and writes during init must be ignored.
        pix_valid_i = 1'b1; pix_idx_i = 4'd2;
        wr_en_i = 1'b1; wr_bank_i = 1'b0; wr_idx_i = 4'd2; wr_rgb_i = 12'h555;
        wait_init("init_len");
        clear_inputs();

        look(4'd0, 1'b0);
        look(4'd1, 1'b0);
        look(4'd2, 1'b0);
        idle(3);

        // Write and bank switch in the same cycle both take effect.
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 12'h123, 1'b1, 1'b1);
        look(4'd3, 1'b0);
        idle(3);

        // Full stream on bank 1, switching to bank 0 while idx 4 is issued.
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd10, 12'h5A5, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, (i == 4), 1'b0);
        idle(3);

        // Same-entry read and write: old value now, new value next cycle.
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd5, 12'hABC, 1'b0, 1'b0);
        look(4'd5, 1'b0);
        idle(3);

        look(4'd1, 1'b1);
        look(4'd0, 1'b1);
        idle(3);

        // Reset during RUN flushes the in-flight pixel and restores defaults.
        look(4'd1, 1'b0);
        sb.delete();
        Reset_n = 1'b0;
        tick();
        chk("run_reset_rgb", {20'd0, red_o, green_o, blue_o}, 32'd0);
        chk("run_reset_busy", {31'd0, init_busy_o}, 32'd1);
        Reset_n = 1'b1;
        model_reset();
        wait_init("reinit_len");
        look(4'd5, 1'b0);
        look(4'd10, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b1);
        look(4'd3, 1'b0);
        idle(4);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
